calc_display: RTL and testbench

CALC_DISPLAY -- requirements
Module: calc_display

---
 rtl/calc_pkg.sv | 59 +++++
 rtl/seg7_dec.sv | 17 +
 rtl/calc_display.sv | 115 +++++++++++
 tb/tb_calc_display.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared constants for the calculator display: status codes, digit count and
// active-low 7-segment patterns (bit order g..a).
package calc_pkg;

    localparam int NUM_DIGITS = 8;

    localparam logic [1:0] STATUS_ERRO  = 2'b00;
    localparam logic [1:0] STATUS_BUSY  = 2'b01;
    localparam logic [1:0] STATUS_READY = 2'b10;

    typedef logic [3:0] bcd_t;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_R     = 7'h2F;
    localparam logic [6:0] SEG_O     = 7'h23;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic logic [6:0] seg_digit(input bcd_t v);
        logic [6:0] p;
        case (v)
            4'd0:    p = SEG_0;
            4'd1:    p = SEG_1;
            4'd2:    p = SEG_2;
            4'd3:    p = SEG_3;
            4'd4:    p = SEG_4;
            4'd5:    p = SEG_5;
            4'd6:    p = SEG_6;
            4'd7:    p = SEG_7;
            4'd8:    p = SEG_8;
            4'd9:    p = SEG_9;
            default: p = SEG_DASH;
        endcase
        return p;
    endfunction

    // "Erro" sits on digits 3..0; upper digits stay dark
    function automatic logic [6:0] err_pattern(input logic [2:0] idx);
        logic [6:0] p;
        case (idx)
            3'd3:       p = SEG_E;
            3'd2, 3'd1: p = SEG_R;
            3'd0:       p = SEG_O;
            default:    p = SEG_BLANK;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/seg7_dec.sv
// Combinational BCD to active-low 7-segment decoder; non-decimal values show a dash.
module seg7_dec
    import calc_pkg::*;
(
    input  logic [3:0] value,
    input  logic       blank,
    output logic [6:0] pattern
);

    always_comb begin
        pattern = seg_digit(value);
        if (blank) begin
            pattern = SEG_BLANK;
        end
    end

endmodule

// File: rtl/calc_display.sv
// Eight-digit multiplexed display for the calculator: double-buffered digit
// capture, frame commit on busy->ready, sticky error screen and scan refresh.
module calc_display
    import calc_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] status,
    input  logic [3:0] data,
    input  logic [3:0] pos,
    output logic [7:0] an,
    output logic [6:0] seg,
    output logic       frame_done,
    output logic       err
);

    localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

    logic [3:0]       shadow [NUM_DIGITS];
    logic [3:0]       active [NUM_DIGITS];
    logic [1:0]       status_q;
    logic [DIV_W-1:0] div_cnt;
    logic [2:0]       scan_idx;

    logic             capture;
    logic             commit;
    logic             lz_blank;
    logic [6:0]       dec_pattern;
    logic [6:0]       seg_next;
    logic [7:0]       an_next;

    // pos[3] set means index 8..15, which is dropped
    assign capture = !err && (status == STATUS_BUSY) && !pos[3];
    assign commit  = !err && (status_q == STATUS_BUSY) && (status == STATUS_READY);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
            status_q   <= STATUS_READY;
            frame_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            status_q   <= status;
            frame_done <= commit;
            if (status == STATUS_ERRO) begin
                err <= 1'b1;
            end
            if (capture) begin
                shadow[pos[2:0]] <= data;
            end
            if (commit) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    active[i] <= shadow[i];
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            div_cnt  <= '0;
            scan_idx <= 3'd0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt  <= '0;
            scan_idx <= scan_idx + 3'd1;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // A digit is a leading zero when it and every higher digit are zero
    always_comb begin
        lz_blank = 1'b0;
        if (BLANK_LZ && (scan_idx != 3'd0)) begin
            lz_blank = 1'b1;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if ((i >= int'(scan_idx)) && (active[i] != 4'd0)) begin
                    lz_blank = 1'b0;
                end
            end
        end
    end

    seg7_dec u_seg7_dec (
        .value   (active[scan_idx]),
        .blank   (lz_blank),
        .pattern (dec_pattern)
    );

    always_comb begin
        seg_next = dec_pattern;
        if (err) begin
            seg_next = err_pattern(scan_idx);
        end
        an_next = ~(8'h01 << scan_idx);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            an  <= 8'hFF;
            seg <= SEG_BLANK;
        end else begin
            an  <= an_next;
            seg <= seg_next;
        end
    end

endmodule

// File: tb/tb_calc_display.sv
// Randomized self-checking bench for calc_display against a behavioural model
// of frames, sticky error and the scanned display.
module tb_calc_display;
    import calc_pkg::*;

    logic       clock;
    logic       reset;
    logic [1:0] status;
    logic [3:0] data;
    logic [3:0] pos;
    logic [7:0] an, an_nolz;
    logic [6:0] seg, seg_nolz;
    logic       frame_done, frame_done_nolz;
    logic       err, err_nolz;

    int checks = 0;
    int errors = 0;

    logic [3:0] m_shadow [8];
    logic [3:0] m_active [8];
    logic       m_err;
    logic [1:0] m_status_q;

    logic [6:0] dig_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    calc_display #(.REFRESH_DIV(4), .BLANK_LZ(1'b1)) dut (
        .clock(clock), .reset(reset), .status(status), .data(data), .pos(pos),
        .an(an), .seg(seg), .frame_done(frame_done), .err(err));

    calc_display #(.REFRESH_DIV(4), .BLANK_LZ(1'b0)) dut_nolz (
        .clock(clock), .reset(reset), .status(status), .data(data), .pos(pos),
        .an(an_nolz), .seg(seg_nolz), .frame_done(frame_done_nolz), .err(err_nolz));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_shadow[i] = 4'd0;
            m_active[i] = 4'd0;
        end
        m_err = 1'b0;
        m_status_q = 2'b10;
    endtask

    function automatic logic [6:0] exp_seg(input int d, input bit lz);
        bit all_zero;
        if (m_err) begin
            if (d == 3) return 7'h06;
            if (d == 2 || d == 1) return 7'h2F;
            if (d == 0) return 7'h23;
            return 7'h7F;
        end
        if (lz && d > 0) begin
            all_zero = 1'b1;
            for (int k = d; k < 8; k++) if (m_active[k] != 4'd0) all_zero = 1'b0;
            if (all_zero) return 7'h7F;
        end
        if (m_active[d] > 4'd9) return 7'h3F;
        return dig_tab[m_active[d]];
    endfunction

    // Drive one cycle of inputs, advance the model at the edge, check pulse and flag
    task automatic step(input logic [1:0] st, input logic [3:0] d, input logic [3:0] p);
        bit exp_fd;
        status = st;
        data   = d;
        pos    = p;
        @(posedge clock);
        exp_fd = !m_err && (m_status_q == 2'b01) && (st == 2'b10);
        if (exp_fd) m_active = m_shadow;
        if (!m_err && st == 2'b01 && p < 4'd8) m_shadow[p[2:0]] = d;
        if (st == 2'b00) m_err = 1'b1;
        m_status_q = st;
        @(negedge clock);
        check("frame_done", frame_done, exp_fd);
        check("frame_done_nolz", frame_done_nolz, exp_fd);
        check("err", err, m_err);
    endtask

    task automatic check_display(input string tag);
        bit [7:0] seen;
        int budget;
        repeat (2) step(2'b10, 4'd0, 4'd0);
        seen = 8'h00;
        budget = 0;
        while (seen != 8'hFF && budget < 64) begin
            for (int d = 0; d < 8; d++) begin
                if (an == ~(8'h01 << d) && !seen[d]) begin
                    check($sformatf("%s_seg_d%0d", tag, d), seg, exp_seg(d, 1'b1));
                    check($sformatf("%s_seg_nolz_d%0d", tag, d), seg_nolz, exp_seg(d, 1'b0));
                    seen[d] = 1'b1;
                end
            end
            step(2'b10, 4'd0, 4'd0);
            budget++;
        end
        if (seen != 8'hFF) check({tag, "_scan_timeout"}, seen, 8'hFF);
    endtask

    task automatic write_frame(input logic [3:0] v [8]);
        for (int i = 0; i < 8; i++) step(2'b01, v[i], 4'(i));
        step(2'b10, 4'd0, 4'd0);
    endtask

    initial begin
        logic [3:0] fr [8];
        logic [7:0] prev_an;
        int run;
        bit changed;
        int n;

        status = 2'b10;
        data = 4'd0;
        pos = 4'd0;
        reset = 1'b0;
        model_reset();
        #12;
        check("rst_an", an, 8'hFF);
        check("rst_seg", seg, 7'h7F);
        check("rst_frame_done", frame_done, 1'b0);
        check("rst_err", err, 1'b0);
        @(negedge clock);
        reset = 1'b1;

        check_display("init");

        fr = '{4'd3, 4'd2, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
        write_frame(fr);
        check_display("frame123");

        step(2'b01, 4'd9, 4'd0);
        step(2'b10, 4'd0, 4'd0);
        check_display("partial129");

        step(2'b01, 4'd5, 4'd9);
        step(2'b01, 4'd12, 4'd0);
        step(2'b10, 4'd0, 4'd0);
        check_display("dash");

        fr = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
        write_frame(fr);
        check_display("zeros");

        // Scan cadence: each an value held REFRESH_DIV cycles, rotating one position
        prev_an = an;
        run = 0;
        changed = 1'b0;
        for (int c = 0; c < 40; c++) begin
            step(2'b10, 4'd0, 4'd0);
            check("an_onehot", $countones(~an), 1);
            if (an == prev_an) begin
                run++;
            end else begin
                if (changed) check("an_hold", run, 4);
                check("an_step", an, {prev_an[6:0], prev_an[7]});
                changed = 1'b1;
                run = 1;
                prev_an = an;
            end
        end

        for (int f = 0; f < 8; f++) begin
            n = $urandom_range(1, 12);
            for (int w = 0; w < n; w++) begin
                if ($urandom_range(0, 9) == 0)
                    step(2'b11, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
                else
                    step(2'b01, ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15)),
                         4'($urandom_range(0, 15)));
            end
            step(2'b01, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 7)));
            step(2'b10, 4'd0, 4'd0);
            check_display($sformatf("rand%0d", f));
        end

        step(2'b00, 4'd0, 4'd0);
        for (int w = 0; w < 10; w++) begin
            step(($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10,
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 7)));
        end
        step(2'b01, 4'd7, 4'd1);
        step(2'b10, 4'd0, 4'd0);
        check_display("error");

        // Reset in the middle of a frame
        for (int w = 0; w < 4; w++) step(2'b01, 4'(w + 5), 4'(w));
        status = 2'b01;
        #2;
        reset = 1'b0;
        status = 2'b10;
        model_reset();
        #1;
        check("midrst_an", an, 8'hFF);
        check("midrst_seg", seg, 7'h7F);
        check("midrst_frame_done", frame_done, 1'b0);
        check("midrst_err", err, 1'b0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        check_display("after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=%0d expected=%0d", 1, 0);
        $fatal(1, "timeout");
    end

endmodule
